// File: rtl/pe_border_mc.sv
// Left-border unary-temporal PE: latches one activation and CH weights, streams the
// activation as temporal unary bits and accumulates CH signed products into the partial sums.
module pe_border_mc #(
  parameter int IWIDTH     = 8,
  parameter int OWIDTH     = 16,
  parameter int CH         = 2,
  parameter int EARLY_TERM = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [IWIDTH-1:0] ifm,
  input  logic                     en_w,
  input  logic                     clr_w,
  input  logic [CH-1:0]            wght_sign,
  input  logic [CH*(IWIDTH-1)-1:0] wght_abs,
  input  logic                     start,
  input  logic [CH*OWIDTH-1:0]     ofm,
  output logic                     busy,
  output logic                     mac_done_d,
  output logic                     en_i_d,
  output logic                     clr_i_d,
  output logic                     en_w_d,
  output logic                     clr_w_d,
  output logic                     start_d,
  output logic                     ifm_sign_d,
  output logic                     ifm_bit_d,
  output logic [IWIDTH-2:0]        randW_d,
  output logic [CH-1:0]            wght_sign_d,
  output logic [CH*(IWIDTH-1)-1:0] wght_abs_d,
  output logic [CH*OWIDTH-1:0]     ofm_d
);

  localparam int MW = IWIDTH - 1;
  localparam int AW = IWIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [MW-1:0]           a_mag;
  logic [MW-1:0]           cnt;
  logic signed [AW-1:0]    acc [CH];
  logic [CH*OWIDTH-1:0]    ofm_hold;

  logic [IWIDTH-1:0]       ifm_neg;
  logic [IWIDTH-1:0]       abs_full;
  logic [MW-1:0]           abs_sat;
  logic [MW-1:0]           last_cnt;
  logic [MW-1:0]           r;
  logic                    ibit;
  logic signed [AW-1:0]    acc_step [CH];
  logic signed [OWIDTH:0]  ofm_x [CH];
  logic signed [OWIDTH:0]  acc_x [CH];
  logic signed [OWIDTH:0]  sum [CH];
  logic [CH*OWIDTH-1:0]    sat_flat;

  // The most negative activation has no positive twin in MW bits, so it clamps to all ones.
  assign ifm_neg  = -ifm;
  assign abs_full = ifm[IWIDTH-1] ? ifm_neg : ifm;
  assign abs_sat  = abs_full[IWIDTH-1] ? {MW{1'b1}} : abs_full[MW-1:0];
  assign last_cnt = (EARLY_TERM != 0) ? a_mag - MW'(1) : {MW{1'b1}};
  assign ibit     = (cnt < a_mag);

  always_comb begin
    r = '0;
    for (int i = 0; i < MW; i++) r[i] = cnt[MW-1-i];
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      acc_step[c] = acc[c];
      if (ibit && (r < wght_abs_d[c*MW +: MW])) begin
        if (ifm_sign_d ^ wght_sign_d[c]) acc_step[c] = acc[c] - AW'(1);
        else                             acc_step[c] = acc[c] + AW'(1);
      end
    end
  end

  // One extra bit of headroom detects overflow; a sign disagreement in the top two bits clamps.
  always_comb begin
    sat_flat = '0;
    for (int c = 0; c < CH; c++) begin
      ofm_x[c] = {ofm[c*OWIDTH+OWIDTH-1], ofm[c*OWIDTH +: OWIDTH]};
      acc_x[c] = {{(OWIDTH+1-AW){acc[c][AW-1]}}, acc[c]};
      sum[c]   = ofm_x[c] + acc_x[c];
      if (sum[c][OWIDTH] != sum[c][OWIDTH-1])
        sat_flat[c*OWIDTH +: OWIDTH] = sum[c][OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                                      : {1'b0, {(OWIDTH-1){1'b1}}};
      else
        sat_flat[c*OWIDTH +: OWIDTH] = sum[c][OWIDTH-1:0];
    end
  end

  // The new result is visible during DONE itself, then held until the next DONE.
  always_comb begin
    ofm_d = ofm_hold;
    if (state == DONE) ofm_d = sat_flat;
  end

  assign busy       = (state != IDLE);
  assign mac_done_d = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_mag       <= '0;
      cnt         <= '0;
      ofm_hold    <= '0;
      en_i_d      <= 1'b0;
      clr_i_d     <= 1'b0;
      en_w_d      <= 1'b0;
      clr_w_d     <= 1'b0;
      start_d     <= 1'b0;
      ifm_sign_d  <= 1'b0;
      ifm_bit_d   <= 1'b0;
      randW_d     <= '0;
      wght_sign_d <= '0;
      wght_abs_d  <= '0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      en_i_d    <= en_i;
      clr_i_d   <= clr_i;
      en_w_d    <= en_w;
      clr_w_d   <= clr_w;
      start_d   <= start;
      ifm_bit_d <= (state == RUN) && ibit;
      randW_d   <= (state == RUN) ? r : '0;
      case (state)
        IDLE: begin
          if (clr_i) begin
            ifm_sign_d <= 1'b0;
            a_mag      <= '0;
          end else if (en_i) begin
            ifm_sign_d <= ifm[IWIDTH-1];
            a_mag      <= abs_sat;
          end
          if (clr_w) begin
            wght_sign_d <= '0;
            wght_abs_d  <= '0;
          end else if (en_w) begin
            wght_sign_d <= wght_sign;
            wght_abs_d  <= wght_abs;
          end
          if (start) begin
            cnt <= '0;
            for (int c = 0; c < CH; c++) acc[c] <= '0;
            state <= ((EARLY_TERM != 0) && (a_mag == '0)) ? DONE : RUN;
          end
        end
        RUN: begin
          cnt <= cnt + MW'(1);
          for (int c = 0; c < CH; c++) acc[c] <= acc_step[c];
          if (cnt == last_cnt) state <= DONE;
        end
        DONE: begin
          ofm_hold <= sat_flat;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_border_mc.md
# pe_border_mc

Multi-channel, parametrised successor of the unary-temporal border processing element in the systolic array. It latches one signed input activation and CH signed weights, and generates a temporal-unary input bitstream with a bit-reversed-counter random source. It multiplies the input stream against all CH weights in parallel, accumulates signed product bits per channel, and adds the results to the incoming partial sums with saturation. It sits on the left array border, forwards its input stream, random source and control to the interior PEs, and forwards weights downward, all under a start/busy/done handshake with optional early termination.

## Interface
- IWIDTH, 8: activation/weight width incl. sign; magnitude is IWIDTH-1 bits, stream length L = 2^(IWIDTH-1).
- OWIDTH, 16: partial-sum width per channel, signed.
- CH, 2: number of weight channels (≥1).
- EARLY_TERM, 1: 1 ends the MAC after |ifm| cycles; 0 always runs L cycles.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- en_i / clr_i  in  1 each  load / clear the input register (clr wins).
- ifm  in  IWIDTH  signed activation.
- en_w / clr_w  in  1 each  load / clear all weight registers (clr wins).
- wght_sign  in  CH  per-channel weight sign.
- wght_abs  in  CH*(IWIDTH-1)  per-channel weight magnitude; channel c is in slice [c*(IWIDTH-1) +: IWIDTH-1].
- start  in  1  begin a MAC.
- ofm  in  CH*OWIDTH  signed incoming partial sums.
- busy  out  1  high in RUN and DONE.
- mac_done_d  out  1  one-cycle pulse: ofm_d updated.
- en_i_d, clr_i_d, en_w_d, clr_w_d, start_d  out  1 each  control delayed by one cycle.
- ifm_sign_d, ifm_bit_d  out  1 each  registered input sign / temporal bit.
- randW_d  out  IWIDTH-1  registered random value.
- wght_sign_d, wght_abs_d  out  CH, CH*(IWIDTH-1)  registered weights.
- ofm_d  out  CH*OWIDTH  signed output partial sums.

## Operation
- Input register:
  - Stores sign and magnitude a = |ifm|; ifm = -2^(IWIDTH-1) saturates to a = 2^(IWIDTH-1)-1.
  - en_i/clr_i take effect only in IDLE and are ignored while busy.
- Weight registers: b_c and s_c are loaded only in IDLE and ignored while busy; they are directly visible on wght_*_d.
- FSM states:
  - IDLE → RUN on start (cnt←0, acc_c←0).
  - IDLE → DONE instead if EARLY_TERM=1 and a=0.
  - RUN → DONE when cnt reaches its last value: a-1 if EARLY_TERM, else L-1.
  - DONE → IDLE unconditionally.
  - start is ignored when not IDLE.
- Each RUN cycle, with k = cnt:
  - ibit = (k < a).
  - r = bit-reverse of k over IWIDTH-1 bits.
  - p_c = ibit & (r < b_c).
  - acc_c += (sign_i ^ s_c) ? -p_c : +p_c.
  - cnt increments.
- Accumulator acc_c is signed, IWIDTH+1 bits; it cannot overflow because |acc_c| ≤ L.
- In DONE:
  - ofm_d[c] ← saturate_OWIDTH(ofm[c] + acc_c); the add is done at OWIDTH+1 bits and clamped to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1].
  - mac_done_d = 1.
- ofm_d holds its value until the next DONE.
- Forwarding registers:
  - ifm_bit_d and randW_d are ibit and r registered each RUN cycle, and 0 outside RUN.
  - ifm_sign_d follows the input register.

## Timing
- Reset: every output and internal register is 0, the FSM is in IDLE, and cnt = 0.
- Reset mid-MAC aborts the MAC; no mac_done_d is issued.
- start sampled at edge t: first RUN cycle is t+1, and mac_done_d and the new ofm_d appear at t+n+1.
  - n = a if EARLY_TERM, else L.
  - a=0 with EARLY_TERM: mac_done_d appears at t+1.
- busy is high from t+1 through the DONE cycle; start is accepted again the cycle after DONE.
- All *_d control outputs are exactly one-cycle registered copies of their inputs, independent of FSM state.
- ifm_bit_d and randW_d lag the internal stream by one cycle, so an interior neighbour sees bit k at RUN cycle k+1.
- ofm is sampled only in the DONE cycle.

## Test plan
- IWIDTH=8, EARLY_TERM=1: ifm=64, w0=+64, w1=+0, ofm=(100,5), start → 64 RUN cycles, then mac_done_d; ofm_d=(132,5).
- Sign handling: ifm=-64, w0=+64, w1=-64, ofm=(100,100) → ofm_d=(68,132).
- EARLY_TERM=0, same stimulus as the first scenario → busy for 129 cycles, mac_done_d at t+129, ofm_d=(132,5); ifm_bit_d is 0 for stream bits 64..127.
- ifm=-128 (saturated to 127), w0=-127, ofm0=-32768 → acc=+127, ofm_d[0]=-32641; then ofm0=32767 with ifm=127, w0=+127 → ofm_d[0]=32767 (clamped).
- ifm=0, EARLY_TERM=1 → mac_done_d at t+1 and ofm_d=ofm; start held high during busy, and en_w/en_i asserted mid-RUN → ignored, registers unchanged.
- rst asserted at RUN cycle 10 → next cycle all outputs 0, busy=0, no mac_done_d; a following start runs a full correct MAC.
